// File: rtl/imm_encoder_if.sv
// Request/response bus of the immediate encoder: one request channel, one
// encoded-word channel, plus the error counter observed by the consumer.
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  imm_op;
    logic [31:0] imm;
    logic [31:0] base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic        imm_err;
    logic [7:0]  err_count;

    modport slave (
        input  in_valid, imm_op, imm, base, out_ready,
        output in_ready, out_valid, instruction, imm_err, err_count
    );

    modport master (
        output in_valid, imm_op, imm, base, out_ready,
        input  in_ready, out_valid, instruction, imm_err, err_count
    );
endinterface

// File: rtl/imm_encoder.sv
// Packs a signed immediate into the immediate field of an RV32 instruction
// word, flags unrepresentable values, and buffers results in a 2-entry skid.
module imm_encoder (
    input logic         clk,
    input logic         rst_n,
    imm_encoder_if.slave bus
);

    typedef enum logic [2:0] {
        FMT_I = 3'b001,
        FMT_S = 3'b010,
        FMT_B = 3'b011,
        FMT_U = 3'b100,
        FMT_J = 3'b101
    } imm_fmt_e;

    logic [31:0] enc_instr;
    logic        enc_err;

    logic        out_valid_q;
    logic [31:0] out_instr_q;
    logic        out_err_q;
    logic        skid_valid_q;
    logic [31:0] skid_instr_q;
    logic        skid_err_q;
    logic [7:0]  err_cnt_q;

    logic accept;
    logic drain;
    logic out_free;

    // A value fits in N signed bits when all bits from N-1 upward agree.
    always_comb begin
        enc_instr = bus.base;
        enc_err   = 1'b1;
        case (bus.imm_op)
            FMT_I: begin
                enc_instr[31:20] = bus.imm[11:0];
                enc_err          = ~((&bus.imm[31:11]) | ~(|bus.imm[31:11]));
            end
            FMT_S: begin
                enc_instr[31:25] = bus.imm[11:5];
                enc_instr[11:7]  = bus.imm[4:0];
                enc_err          = ~((&bus.imm[31:11]) | ~(|bus.imm[31:11]));
            end
            FMT_B: begin
                enc_instr[31]    = bus.imm[12];
                enc_instr[30:25] = bus.imm[10:5];
                enc_instr[11:8]  = bus.imm[4:1];
                enc_instr[7]     = bus.imm[11];
                enc_err          = bus.imm[0] | ~((&bus.imm[31:12]) | ~(|bus.imm[31:12]));
            end
            FMT_U: begin
                enc_instr[31:12] = bus.imm[31:12];
                enc_err          = |bus.imm[11:0];
            end
            FMT_J: begin
                enc_instr[31]    = bus.imm[20];
                enc_instr[30:21] = bus.imm[10:1];
                enc_instr[20]    = bus.imm[11];
                enc_instr[19:12] = bus.imm[19:12];
                enc_err          = bus.imm[0] | ~((&bus.imm[31:20]) | ~(|bus.imm[31:20]));
            end
            default: begin
                enc_instr = bus.base;
                enc_err   = 1'b1;
            end
        endcase
    end

    assign accept   = bus.in_valid & ~skid_valid_q;
    assign drain    = out_valid_q & bus.out_ready;
    assign out_free = ~out_valid_q | bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_err_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            if (out_free) begin
                if (skid_valid_q) begin
                    out_valid_q  <= 1'b1;
                    out_instr_q  <= skid_instr_q;
                    out_err_q    <= skid_err_q;
                    skid_valid_q <= accept;
                    if (accept) begin
                        skid_instr_q <= enc_instr;
                        skid_err_q   <= enc_err;
                    end
                end else begin
                    out_valid_q <= accept;
                    if (accept) begin
                        out_instr_q <= enc_instr;
                        out_err_q   <= enc_err;
                    end
                end
            end else if (accept) begin
                // Output is held, so the new word parks in the skid entry.
                skid_valid_q <= 1'b1;
                skid_instr_q <= enc_instr;
                skid_err_q   <= enc_err;
            end

            if (drain && out_err_q && (err_cnt_q != 8'hFF))
                err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.in_ready    = ~skid_valid_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.instruction = out_instr_q;
    assign bus.imm_err     = out_err_q;
    assign bus.err_count   = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed vector table, hand-written backpressure/reset/saturation sequences
// and a randomized round-trip against a RISC-V immediate decoder.
module tb_imm_encoder;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    imm_encoder_if bus ();

    imm_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] imm;
        logic [31:0] base;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] imm;
        logic [31:0] base;
    } req_t;

    function automatic logic [31:0] dec_imm(input logic [2:0] op, input logic [31:0] i);
        case (op)
            3'b001:  return {{20{i[31]}}, i[31:20]};
            3'b010:  return {{20{i[31]}}, i[31:25], i[11:7]};
            3'b011:  return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'b100:  return {i[31:12], 12'b0};
            3'b101:  return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] field_mask(input logic [2:0] op);
        case (op)
            3'b001:  return 32'hFFF00000;
            3'b010:  return 32'hFE000F80;
            3'b011:  return 32'hFE000F80;
            3'b100:  return 32'hFFFFF000;
            3'b101:  return 32'hFFFFF000;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_imm(input logic [2:0] op, input logic [31:0] r);
        case (op)
            3'b001, 3'b010: return {{20{r[11]}}, r[11:0]};
            3'b011:         return {{19{r[12]}}, r[12:1], 1'b0};
            3'b100:         return {r[31:12], 12'b0};
            default:        return {{11{r[20]}}, r[20:1], 1'b0};
        endcase
    endfunction

    task automatic drive(input logic [2:0] op, input logic [31:0] imm, input logic [31:0] base);
        bus.in_valid = 1'b1;
        bus.imm_op   = op;
        bus.imm      = imm;
        bus.base     = base;
    endtask

    vec_t vecs[16];
    req_t sb[$];
    req_t cur;
    req_t e;
    int exp_errs;
    logic [31:0] got[3];
    int got_cyc[3];
    int ngot;

    initial begin
        vecs[0]  = '{3'b001, 32'hFFFFFFFF, 32'h00000013, 32'hFFF00013, 1'b0};
        vecs[1]  = '{3'b011, 32'h00000800, 32'h00000063, 32'h000000E3, 1'b0};
        vecs[2]  = '{3'b011, 32'h00000801, 32'h00000063, 32'h000000E3, 1'b1};
        vecs[3]  = '{3'b100, 32'h12345000, 32'h00000037, 32'h12345037, 1'b0};
        vecs[4]  = '{3'b010, 32'h00000800, 32'h00000023, 32'h80000023, 1'b1};
        vecs[5]  = '{3'b101, 32'hFFFFFFFE, 32'h0000006F, 32'hFFFFF06F, 1'b0};
        vecs[6]  = '{3'b111, 32'h00000005, 32'h0000006F, 32'h0000006F, 1'b1};
        vecs[7]  = '{3'b001, 32'h00000005, 32'hFFF00093, 32'h00500093, 1'b0};
        vecs[8]  = '{3'b001, 32'h000007FF, 32'h00000013, 32'h7FF00013, 1'b0};
        vecs[9]  = '{3'b001, 32'h00000800, 32'h00000013, 32'h80000013, 1'b1};
        vecs[10] = '{3'b001, 32'hFFFFF800, 32'h00000013, 32'h80000013, 1'b0};
        vecs[11] = '{3'b010, 32'hFFFFFFFC, 32'h00112023, 32'hFE112E23, 1'b0};
        vecs[12] = '{3'b100, 32'h12345001, 32'h00000037, 32'h12345037, 1'b1};
        vecs[13] = '{3'b101, 32'h00100000, 32'h0000006F, 32'h8000006F, 1'b1};
        vecs[14] = '{3'b011, 32'hFFFFF000, 32'h00000063, 32'h80000063, 1'b0};
        vecs[15] = '{3'b000, 32'h00000000, 32'h12345678, 32'h12345678, 1'b1};

        bus.in_valid  = 1'b0;
        bus.imm_op    = 3'b000;
        bus.imm       = '0;
        bus.base      = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_instruction", bus.instruction, 0);
        chk("rst_imm_err", bus.imm_err, 0);
        chk("rst_err_count", bus.err_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table, back-to-back with out_ready=1
        exp_errs = 0;
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].op, vecs[i].imm, vecs[i].base);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), bus.out_valid, 1);
            chk($sformatf("vec%0d_instr", i), bus.instruction, vecs[i].exp_instr);
            chk($sformatf("vec%0d_err", i), bus.imm_err, vecs[i].exp_err);
            exp_errs += int'(vecs[i].exp_err);
        end
        @(posedge clk); #1;
        chk("table_drained", bus.out_valid, 0);
        chk("table_err_count", bus.err_count, exp_errs);

        // Backpressure: A, B, C with out_ready low for 4 cycles
        bus.out_ready = 1'b0;
        drive(3'b001, 32'h00000001, 32'h00000013);
        @(posedge clk); #1;
        chk("bp_a_out", bus.instruction, 32'h00100013);
        chk("bp_a_in_ready", bus.in_ready, 1);
        drive(3'b001, 32'h00000002, 32'h00000013);
        @(posedge clk); #1;
        chk("bp_b_in_ready", bus.in_ready, 0);
        drive(3'b001, 32'h00000003, 32'h00000013);
        @(posedge clk); #1;
        chk("bp_c_stalled", bus.in_ready, 0);
        chk("bp_hold_instr", bus.instruction, 32'h00100013);
        @(posedge clk); #1;
        chk("bp_hold_instr2", bus.instruction, 32'h00100013);
        chk("bp_hold_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        ngot = 0;
        for (int k = 0; k < 8; k++) begin
            logic acc;
            acc = bus.in_valid & bus.in_ready;
            if (bus.out_valid && ngot < 3) begin
                got[ngot] = bus.instruction;
                got_cyc[ngot] = k;
                ngot++;
            end
            @(posedge clk); #1;
            if (acc) bus.in_valid = 1'b0;
        end
        chk("bp_count", ngot, 3);
        chk("bp_order_a", got[0], 32'h00100013);
        chk("bp_order_b", got[1], 32'h00200013);
        chk("bp_order_c", got[2], 32'h00300013);
        chk("bp_no_gap", got_cyc[2] - got_cyc[0], 2);

        // Reset with two entries buffered
        bus.out_ready = 1'b0;
        drive(3'b001, 32'h00000001, 32'h00000013);
        @(posedge clk); #1;
        drive(3'b001, 32'h00000002, 32'h00000013);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("pre_rst_full", bus.in_ready, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_err_count", bus.err_count, 0);
        chk("mid_rst_instr", bus.instruction, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        drive(3'b011, 32'h00000801, 32'h00000063);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("post_rst_valid", bus.out_valid, 1);
        chk("post_rst_instr", bus.instruction, 32'h000000E3);
        chk("post_rst_err", bus.imm_err, 1);
        @(posedge clk); #1;
        chk("post_rst_err_count", bus.err_count, 1);

        // err_count saturation
        drive(3'b000, 32'h0, 32'h0);
        repeat (260) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("err_count_sat", bus.err_count, 255);

        // Randomized round-trip with random backpressure
        begin
            int sent, rcvd, cyc;
            sent = 0; rcvd = 0; cyc = 0;
            cur.op = 3'($urandom_range(1, 5));
            cur.imm = rnd_imm(cur.op, $urandom);
            cur.base = $urandom;
            drive(cur.op, cur.imm, cur.base);
            sent = 1;
            while (rcvd < 10000 && cyc < 80000) begin
                logic acc, xfer;
                acc  = bus.in_valid & bus.in_ready;
                xfer = bus.out_valid & bus.out_ready;
                if (xfer) begin
                    if (sb.size() == 0) begin
                        chk("rr_spurious", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("roundtrip", {bus.imm_err, dec_imm(e.op, bus.instruction)}, {1'b0, e.imm});
                        chk("base_bits", bus.instruction & ~field_mask(e.op), e.base & ~field_mask(e.op));
                    end
                    rcvd++;
                end
                if (acc) sb.push_back(cur);
                @(posedge clk); #1;
                cyc++;
                if (acc) begin
                    if (sent < 10000) begin
                        cur.op = 3'($urandom_range(1, 5));
                        cur.imm = rnd_imm(cur.op, $urandom);
                        cur.base = $urandom;
                        drive(cur.op, cur.imm, cur.base);
                        sent++;
                    end else begin
                        bus.in_valid = 1'b0;
                    end
                end
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            chk("rr_completed", rcvd, 10000);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
